// File: rtl/bus_master.sv
// Initiator for the shared 4-slave bus: command FIFO feeding a registered write/read FSM.
// Optional BUS_MASTER_SEL_ERR_EN adds rsp_err/wr_err and suppresses strobes for out-of-range slaves.
module bus_master #(
   parameter int ADDR_WIDTH       = 3,
   parameter int DATA_WIDTH       = 8,
   parameter int MAX_NO_OF_SLAVES = 4,
   parameter int NO_OF_SLAVES     = 2,
   parameter int CMD_DEPTH        = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        cmd_valid,
   output logic                        cmd_ready,
   input  logic                        cmd_write,
   input  logic [1:0]                  cmd_sel,
   input  logic [ADDR_WIDTH-1:0]       cmd_addr,
   input  logic [DATA_WIDTH-1:0]       cmd_wdata,
   output logic                        rsp_valid,
   input  logic                        rsp_ready,
   output logic [DATA_WIDTH-1:0]       rsp_rdata,
   output logic                        busy,
   output logic [ADDR_WIDTH-1:0]       addr,
   output logic [DATA_WIDTH-1:0]       wdata,
   output logic                        rd,
   output logic                        wr,
   output logic [MAX_NO_OF_SLAVES-1:0] en,
   input  logic [DATA_WIDTH-1:0]       m_rdata
`ifdef BUS_MASTER_SEL_ERR_EN
   ,
   output logic                        rsp_err,
   output logic                        wr_err
`endif
);

   localparam int PW = $clog2(CMD_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [2:0] SEL_LIMIT = 3'(NO_OF_SLAVES);

   typedef enum logic [2:0] {IDLE, WR, RD_ADDR, RD_DATA, RSP_WAIT} state_t;

   state_t state;

   logic                  fifo_write [CMD_DEPTH];
   logic [1:0]            fifo_sel   [CMD_DEPTH];
   logic [ADDR_WIDTH-1:0] fifo_addr  [CMD_DEPTH];
   logic [DATA_WIDTH-1:0] fifo_wdata [CMD_DEPTH];

   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;

   logic full;
   logic empty;
   logic push;
   logic pop;

   logic                        head_write;
   logic [1:0]                  head_sel;
   logic [ADDR_WIDTH-1:0]       head_addr;
   logic [DATA_WIDTH-1:0]       head_wdata;
   logic                        sel_ok;
   logic [MAX_NO_OF_SLAVES-1:0] head_en;

   assign full      = (count == CW'(CMD_DEPTH));
   assign empty     = (count == '0);
   assign cmd_ready = !full;
   assign push      = cmd_valid && cmd_ready;
   assign pop       = (state == IDLE) && !empty;
   assign busy      = !empty || (state != IDLE);

   assign head_write = fifo_write[rd_ptr];
   assign head_sel   = fifo_sel[rd_ptr];
   assign head_addr  = fifo_addr[rd_ptr];
   assign head_wdata = fifo_wdata[rd_ptr];
   assign sel_ok     = ({1'b0, head_sel} < SEL_LIMIT);
   assign head_en    = sel_ok ? (MAX_NO_OF_SLAVES'(1) << head_sel) : '0;

   // Storage needs no reset: occupancy is tracked solely by count.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_write[wr_ptr] <= cmd_write;
         fifo_sel[wr_ptr]   <= cmd_sel;
         fifo_addr[wr_ptr]  <= cmd_addr;
         fifo_wdata[wr_ptr] <= cmd_wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         rd        <= 1'b0;
         wr        <= 1'b0;
         en        <= '0;
         addr      <= '0;
         wdata     <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
`ifdef BUS_MASTER_SEL_ERR_EN
         rsp_err   <= 1'b0;
         wr_err    <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (!empty) begin
                  if (head_write) begin
`ifdef BUS_MASTER_SEL_ERR_EN
                     if (sel_ok) begin
                        wr    <= 1'b1;
                        en    <= head_en;
                        addr  <= head_addr;
                        wdata <= head_wdata;
                     end else begin
                        wr_err <= 1'b1;
                     end
`else
                     wr    <= 1'b1;
                     en    <= head_en;
                     addr  <= head_addr;
                     wdata <= head_wdata;
`endif
                     state <= WR;
                  end else begin
`ifdef BUS_MASTER_SEL_ERR_EN
                     // Bad slave index: skip the bus entirely and answer with an error.
                     if (sel_ok) begin
                        rd    <= 1'b1;
                        en    <= head_en;
                        addr  <= head_addr;
                        state <= RD_ADDR;
                     end else begin
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        state     <= RSP_WAIT;
                     end
`else
                     rd    <= 1'b1;
                     en    <= head_en;
                     addr  <= head_addr;
                     state <= RD_ADDR;
`endif
                  end
               end
            end
            WR: begin
               wr    <= 1'b0;
               en    <= '0;
               addr  <= '0;
               wdata <= '0;
`ifdef BUS_MASTER_SEL_ERR_EN
               wr_err <= 1'b0;
`endif
               state <= IDLE;
            end
            RD_ADDR: begin
               rd    <= 1'b0;
               state <= RD_DATA;
            end
            RD_DATA: begin
               rsp_rdata <= m_rdata;
               rsp_valid <= 1'b1;
               en        <= '0;
               addr      <= '0;
`ifdef BUS_MASTER_SEL_ERR_EN
               rsp_err   <= 1'b0;
`endif
               state     <= RSP_WAIT;
            end
            RSP_WAIT: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bus_master.sv
// Scoreboard bench for bus_master: stimulus pushes expected bus cycles/responses, a monitor pops and compares.
module tb_bus_master;

   localparam int AW = 3;
   localparam int DW = 8;
   localparam int MS = 4;
   localparam int NS = 2;
   localparam int CD = 4;
`ifdef BUS_MASTER_SEL_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic          cmd_write = 1'b0;
   logic [1:0]    cmd_sel = '0;
   logic [AW-1:0] cmd_addr = '0;
   logic [DW-1:0] cmd_wdata = '0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b1;
   logic [DW-1:0] rsp_rdata;
   logic          busy;
   logic [AW-1:0] addr;
   logic [DW-1:0] wdata;
   logic          rd;
   logic          wr;
   logic [MS-1:0] en;
   logic [DW-1:0] m_rdata = '0;
`ifdef BUS_MASTER_SEL_ERR_EN
   logic          rsp_err;
   logic          wr_err;
`endif

   always #5 clk = ~clk;

   bus_master #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_NO_OF_SLAVES(MS),
      .NO_OF_SLAVES(NS), .CMD_DEPTH(CD)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_sel(cmd_sel), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .busy(busy), .addr(addr), .wdata(wdata), .rd(rd), .wr(wr), .en(en),
      .m_rdata(m_rdata)
`ifdef BUS_MASTER_SEL_ERR_EN
      , .rsp_err(rsp_err), .wr_err(wr_err)
`endif
   );

   // Slave model: answers one cycle after rd, muxed by en, 0 when nothing selected.
   logic [DW-1:0] mem [NS][8];
   always @(posedge clk) begin
      if (!rst_n) begin
         for (int s = 0; s < NS; s++)
            for (int a = 0; a < 8; a++)
               mem[s][a] <= '0;
         mem[0][3] <= 8'h3C;
         mem[1][2] <= 8'h5A;
         m_rdata   <= '0;
      end else begin
         m_rdata <= '0;
         for (int s = 0; s < NS; s++) begin
            if (en[s]) begin
               if (rd) m_rdata <= mem[s][addr];
               if (wr) mem[s][addr] <= wdata;
            end
         end
      end
   end

   typedef struct {
      bit            write;
      logic [MS-1:0] en;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } bus_t;

   typedef struct {
      logic [DW-1:0] data;
      bit            err;
   } rsp_t;

   bus_t bus_q[$];
   rsp_t rsp_q[$];

   int pass_cnt = 0;
   int total_cnt = 0;
   int viol_cnt = 0;
   int wr_err_cnt = 0;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic reportFail(input string name);
      total_cnt++;
      $display("[TB] FAIL %s: bound expired or unexpected event", name);
   endtask

   // Monitor: compares every bus strobe and response handshake against the queues.
   bit            lat_arm = 0;
   int            lat_cnt = 0;
   bit            hold_arm = 0;
   logic [MS-1:0] hold_en = '0;

   always @(negedge clk) begin : monitor
      bus_t e;
      rsp_t r;
      if (!rst_n) begin
         lat_arm  = 0;
         hold_arm = 0;
      end else begin
         if (rd && wr) viol_cnt++;
         if ($countones(en) > 1) viol_cnt++;
         if (lat_arm) begin
            lat_cnt++;
            if (rsp_valid) begin
               checkOutput("rd_latency", lat_cnt, 2);
               lat_arm = 0;
            end
         end
         if (hold_arm) begin
            checkOutput("rd_en_hold", {rd, en}, {1'b0, hold_en});
            hold_arm = 0;
         end
         if (rd || wr) begin
            if (bus_q.size() == 0) begin
               reportFail("unexpected_bus_cycle");
            end else begin
               e = bus_q.pop_front();
               checkOutput("bus_kind_wr", wr, e.write);
               checkOutput("bus_en", en, e.en);
               checkOutput("bus_addr", addr, e.addr);
               if (e.write) checkOutput("bus_wdata", wdata, e.wdata);
               if (rd) begin
                  lat_arm  = 1;
                  lat_cnt  = 0;
                  hold_arm = 1;
                  hold_en  = e.en;
               end
            end
         end
         if (rsp_valid && rsp_ready) begin
            if (rsp_q.size() == 0) begin
               reportFail("unexpected_response");
            end else begin
               r = rsp_q.pop_front();
               checkOutput("rsp_rdata", rsp_rdata, r.data);
`ifdef BUS_MASTER_SEL_ERR_EN
               checkOutput("rsp_err", rsp_err, r.err);
`endif
            end
         end
`ifdef BUS_MASTER_SEL_ERR_EN
         if (wr_err) wr_err_cnt++;
`endif
      end
   end

   // Issues one command (blocks until accepted) and records what the bus and response should show.
   task automatic applyStimulus(input bit write, input logic [1:0] sel, input logic [AW-1:0] a,
                                input logic [DW-1:0] d, input logic [MS-1:0] exp_en,
                                input logic [DW-1:0] exp_rdata, input bit track_bus, input bit track_rsp);
      bit skip_bus;
      bit accepted;
      skip_bus = ERR_EN && (exp_en == '0);
      if (track_bus && !skip_bus) bus_q.push_back('{write, exp_en, a, d});
      if (track_rsp && !write) rsp_q.push_back('{skip_bus ? '0 : exp_rdata, skip_bus});
      cmd_valid = 1'b1;
      cmd_write = write;
      cmd_sel   = sel;
      cmd_addr  = a;
      cmd_wdata = d;
      accepted  = 0;
      for (int i = 0; i < 60 && !accepted; i++) begin
         @(negedge clk);
         accepted = cmd_ready;
         @(posedge clk);
         #1;
      end
      if (!accepted) reportFail("cmd_accept_timeout");
      cmd_valid = 1'b0;
   endtask

   task automatic waitIdle();
      for (int i = 0; i < 300; i++) begin
         @(posedge clk);
         #1;
         if (!busy && !rsp_valid && bus_q.size() == 0 && rsp_q.size() == 0) return;
      end
      reportFail("idle_timeout");
   endtask

   task automatic waitRsp();
      for (int i = 0; i < 50; i++) begin
         if (rsp_valid) return;
         @(posedge clk);
         #1;
      end
      reportFail("rsp_timeout");
   endtask

   task automatic checkAllZero(input string name);
      checkOutput({name, "_cmd_ready"}, cmd_ready, 1);
      checkOutput({name, "_busy"}, busy, 0);
      checkOutput({name, "_rd_wr_rspv"}, {rd, wr, rsp_valid}, 0);
      checkOutput({name, "_en_addr"}, {en, addr}, 0);
      checkOutput({name, "_wdata_rdata"}, {wdata, rsp_rdata}, 0);
   endtask

   initial begin
      int bad;
      #3 rst_n = 1'b0;
      #2 checkAllZero("reset");
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      $display("[TB] single write");
      applyStimulus(1, 2'd1, 3'd5, 8'hA5, 4'b0010, 8'h00, 1, 1);
      waitIdle();

      $display("[TB] single read");
      applyStimulus(0, 2'd0, 3'd3, 8'h00, 4'b0001, 8'h3C, 1, 1);
      waitIdle();

      $display("[TB] backpressure");
      rsp_ready = 1'b0;
      applyStimulus(0, 2'd1, 3'd2, 8'h00, 4'b0010, 8'h5A, 1, 1);
      waitRsp();
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (rsp_valid !== 1'b1 || rsp_rdata !== 8'h5A) bad++;
      end
      @(posedge clk);
      #1;
      checkOutput("bp_rsp_stable", bad, 0);
      applyStimulus(1, 2'd0, 3'd2, 8'h22, 4'b0001, 8'h00, 1, 1);
      applyStimulus(0, 2'd0, 3'd2, 8'h00, 4'b0001, 8'h22, 1, 1);
      applyStimulus(1, 2'd1, 3'd4, 8'h44, 4'b0010, 8'h00, 1, 1);
      applyStimulus(0, 2'd1, 3'd4, 8'h00, 4'b0010, 8'h44, 1, 1);
      checkOutput("bp_full_cmd_ready", cmd_ready, 0);
      cmd_valid = 1'b1;
      cmd_write = 1'b1;
      cmd_sel   = 2'd0;
      cmd_addr  = 3'd6;
      cmd_wdata = 8'h66;
      repeat (3) @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      checkOutput("bp_still_full", {cmd_ready, busy, rsp_valid}, 3'b011);
      rsp_ready = 1'b1;
      waitIdle();

      $display("[TB] mixed burst");
      applyStimulus(1, 2'd0, 3'd1, 8'h11, 4'b0001, 8'h00, 1, 1);
      applyStimulus(0, 2'd1, 3'd2, 8'h00, 4'b0010, 8'h5A, 1, 1);
      applyStimulus(1, 2'd1, 3'd7, 8'h77, 4'b0010, 8'h00, 1, 1);
      applyStimulus(0, 2'd0, 3'd1, 8'h00, 4'b0001, 8'h11, 1, 1);
      waitIdle();

      $display("[TB] reset during read");
      applyStimulus(0, 2'd0, 3'd3, 8'h00, 4'b0001, 8'h3C, 1, 0);
      applyStimulus(1, 2'd1, 3'd5, 8'h55, 4'b0010, 8'h00, 0, 0);
      applyStimulus(1, 2'd1, 3'd6, 8'h66, 4'b0010, 8'h00, 0, 0);
      checkOutput("pre_reset_rd_data", {rd, en, busy}, {1'b0, 4'b0001, 1'b1});
      rst_n = 1'b0;
      #1 checkAllZero("midreset");
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (8) @(posedge clk);
      #1 checkOutput("post_reset_busy", {busy, rsp_valid}, 0);

      $display("[TB] out-of-range slave");
      applyStimulus(1, 2'd3, 3'd1, 8'h99, 4'b0000, 8'h00, 1, 1);
      applyStimulus(0, 2'd3, 3'd2, 8'h00, 4'b0000, 8'h00, 1, 1);
      waitIdle();
      checkOutput("wr_err_pulses", wr_err_cnt, ERR_EN ? 1 : 0);

      checkOutput("no_rd_wr_overlap_or_multihot", viol_cnt, 0);
      checkOutput("bus_q_drained", bus_q.size(), 0);
      checkOutput("rsp_q_drained", rsp_q.size(), 0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
